rob_alloc_ctrl: RTL and testbench

Reorder-buffer pointer and capacity controller.
- Owns the ROB write pointer (with wrap bit), the read pointer and the free-entry count.
- Grants or stalls the dispatch stage's per-cycle allocation of up to 4 entries.
- Retires up to 4 entries per cycle on commit, and rewinds the pointers on pipeline flush.
- Drives `ROB_wr_ptr_exp` and `ROB_room` into the dispatch/ROB-ID assignment stage.

---
 rtl/rob_alloc_ctrl.sv | 158 +++++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer pointer/capacity controller: owns wr/rd pointers and free count (ROB_OCC_STATS_EN adds occupancy stats).
// Latency: pointer/room outputs update one cycle after an accepted alloc/retire/flush; fire/stall are combinational.
// Backpressure: alloc_stall holds dispatch during post-flush recovery, on flush, or when the request exceeds room.
module rob_alloc_ctrl #(
    parameter int unsigned ROB_DEPTH      = 64,
    parameter int unsigned PTR_W          = 6,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_vld,
    input  logic [2:0]       alloc_num,
    input  logic             alloc_pause_ext,
    input  logic [2:0]       retire_num,
    output logic             alloc_fire,
    output logic             alloc_stall,
    output logic [PTR_W:0]   ROB_wr_ptr_exp,
    output logic [PTR_W:0]   ROB_rd_ptr_exp,
    output logic [PTR_W:0]   ROB_room,
    output logic             rob_empty,
    output logic             rob_full,
    output logic             retire_err
`ifdef ROB_OCC_STATS_EN
    ,
    output logic [PTR_W:0]   occ_hwm,
    output logic [31:0]      full_stall_cnt
`endif
);

    localparam int unsigned EW = PTR_W + 1;
    localparam logic [EW-1:0] DEPTH_V = EW'(ROB_DEPTH);
    localparam logic [2:0] REC_LOAD = 3'(RECOVER_CYCLES - 1);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    rec_cnt_q, rec_cnt_d;
    logic [EW-1:0] wr_q, rd_q, room_q;
    logic [EW-1:0] wr_d, rd_d, room_d;
    logic          err_q;

    logic [EW-1:0] num_ext;
    logic [EW-1:0] occ;
    logic [2:0]    ret_sat;
    logic [EW-1:0] ret_ext;
    logic          ret_over;
    logic [EW-1:0] ret_eff;
    logic [EW-1:0] alloc_eff;
    logic          room_short;

    assign num_ext    = EW'(alloc_num);
    assign occ        = DEPTH_V - room_q;
    assign ret_sat    = (retire_num > 3'd4) ? 3'd4 : retire_num;
    assign ret_ext    = EW'(ret_sat);
    assign ret_over   = ret_ext > occ;
    assign ret_eff    = ret_over ? occ : ret_ext;
    assign room_short = num_ext > room_q;

    assign alloc_stall = (state_q != RUN) | flush | room_short;
    assign alloc_fire  = alloc_vld & (alloc_num != 3'd0) & ~alloc_stall & ~alloc_pause_ext;
    assign alloc_eff   = alloc_fire ? num_ext : '0;

    // Retire is applied before the flush rewind, so wr snaps to the post-retire rd.
    always_comb begin
        rd_d = rd_q + ret_eff;
        if (flush) begin
            wr_d   = rd_q + ret_eff;
            room_d = DEPTH_V;
        end else begin
            wr_d   = wr_q + alloc_eff;
            room_d = room_q - alloc_eff + ret_eff;
        end
    end

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        unique case (state_q)
            RUN: begin
                if (flush) begin
                    state_d   = RECOVER;
                    rec_cnt_d = REC_LOAD;
                end
            end
            RECOVER: begin
                if (flush) begin
                    rec_cnt_d = REC_LOAD;
                end else if (rec_cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    rec_cnt_d = rec_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d   = RUN;
                rec_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            rec_cnt_q <= 3'd0;
            wr_q      <= '0;
            rd_q      <= '0;
            room_q    <= DEPTH_V;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            room_q    <= room_d;
            if (ret_over) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ROB_wr_ptr_exp = wr_q;
    assign ROB_rd_ptr_exp = rd_q;
    assign ROB_room       = room_q;
    assign rob_empty      = (room_q == DEPTH_V);
    assign rob_full       = (room_q == '0);
    assign retire_err     = err_q;

`ifdef ROB_OCC_STATS_EN
    logic [EW-1:0] hwm_q;
    logic [EW-1:0] occ_d;
    logic [31:0]   stall_cnt_q;

    assign occ_d = DEPTH_V - room_d;

    // Counts only capacity-limited requests, not issue-queue pauses or recovery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (occ_d > hwm_q) begin
                hwm_q <= occ_d;
            end
            if (alloc_vld && !alloc_pause_ext && room_short && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign occ_hwm        = hwm_q;
    assign full_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Scoreboard bench for rob_alloc_ctrl: a queue-of-entries ROB model predicts every cycle's outputs.
module tb_rob_alloc_ctrl;

    localparam int DEPTH = 64;
    localparam int PMOD  = 128;
    localparam int RECOV = 2;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       alloc_vld;
    logic [2:0] alloc_num;
    logic       alloc_pause_ext;
    logic [2:0] retire_num;
    logic       alloc_fire;
    logic       alloc_stall;
    logic [6:0] ROB_wr_ptr_exp;
    logic [6:0] ROB_rd_ptr_exp;
    logic [6:0] ROB_room;
    logic       rob_empty;
    logic       rob_full;
    logic       retire_err;
`ifdef ROB_OCC_STATS_EN
    logic [6:0]  occ_hwm;
    logic [31:0] full_stall_cnt;
`endif

    rob_alloc_ctrl #(.ROB_DEPTH(64), .PTR_W(6), .RECOVER_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .alloc_vld      (alloc_vld),
        .alloc_num      (alloc_num),
        .alloc_pause_ext(alloc_pause_ext),
        .retire_num     (retire_num),
        .alloc_fire     (alloc_fire),
        .alloc_stall    (alloc_stall),
        .ROB_wr_ptr_exp (ROB_wr_ptr_exp),
        .ROB_rd_ptr_exp (ROB_rd_ptr_exp),
        .ROB_room       (ROB_room),
        .rob_empty      (rob_empty),
        .rob_full       (rob_full),
        .retire_err     (retire_err)
`ifdef ROB_OCC_STATS_EN
        ,
        .occ_hwm        (occ_hwm),
        .full_stall_cnt (full_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit     fire;
        bit     stall;
        int     wr;
        int     rd;
        int     room;
        bit     empty;
        bit     full;
        bit     err;
        longint scnt;
        int     hwm;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the ROB is a queue of allocated pointer values.
    int     m_q[$];
    int     m_wr;
    int     m_blk;
    bit     m_err;
    longint m_scnt;
    int     m_hwm;

    task automatic chk(input string nm, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic int m_rd();
        return (m_q.size() > 0) ? m_q[0] : m_wr;
    endfunction

    function automatic int m_room();
        return DEPTH - m_q.size();
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_wr   = 0;
        m_blk  = 0;
        m_err  = 1'b0;
        m_scnt = 0;
        m_hwm  = 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("alloc_fire", alloc_fire, e.fire);
            chk("alloc_stall", alloc_stall, e.stall);
            chk("wr_ptr", ROB_wr_ptr_exp, e.wr);
            chk("rd_ptr", ROB_rd_ptr_exp, e.rd);
            chk("room", ROB_room, e.room);
            chk("rob_empty", rob_empty, e.empty);
            chk("rob_full", rob_full, e.full);
            chk("retire_err", retire_err, e.err);
`ifdef ROB_OCC_STATS_EN
            chk("full_stall_cnt", full_stall_cnt, e.scnt);
            chk("occ_hwm", occ_hwm, e.hwm);
`endif
        end
    end

    function automatic exp_t snap(bit fire, bit stall);
        exp_t e;
        e.fire  = fire;
        e.stall = stall;
        e.wr    = m_wr;
        e.rd    = m_rd();
        e.room  = m_room();
        e.empty = (m_q.size() == 0);
        e.full  = (m_q.size() == DEPTH);
        e.err   = m_err;
        e.scnt  = m_scnt;
        e.hwm   = m_hwm;
        return e;
    endfunction

    task automatic rst_cycle();
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        flush           = 1'b0;
        alloc_vld       = 1'b0;
        alloc_num       = 3'd0;
        alloc_pause_ext = 1'b0;
        retire_num      = 3'd0;
        m_reset();
        sb.push_back(snap(1'b0, 1'b0));
    endtask

    task automatic cyc(input bit vld, input int num, input bit pause, input int ret, input bit fl);
        int  room;
        int  rn;
        int  r;
        bit  stall;
        bit  fire;
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        alloc_vld       = vld;
        alloc_num       = 3'(num);
        alloc_pause_ext = pause;
        retire_num      = 3'(ret);
        flush           = fl;

        room  = m_room();
        stall = (m_blk > 0) || fl || (num > room);
        fire  = vld && (num != 0) && !stall && !pause;
        sb.push_back(snap(fire, stall));

        rn = (ret > 4) ? 4 : ret;
        r  = (rn > m_q.size()) ? m_q.size() : rn;
        if (rn > m_q.size()) m_err = 1'b1;
        if (vld && !pause && (num > room) && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        repeat (r) void'(m_q.pop_front());
        if (fl) begin
            m_wr  = m_rd();
            m_q.delete();
            m_blk = RECOV;
        end else begin
            if (fire) begin
                for (int k = 0; k < num; k++) begin
                    m_q.push_back(m_wr);
                    m_wr = (m_wr + 1) % PMOD;
                end
            end
            if (m_blk > 0) m_blk--;
        end
        if (m_q.size() > m_hwm) m_hwm = m_q.size();
    endtask

    task automatic drain();
        int guard = 0;
        while (m_q.size() > 0 && guard < 100) begin
            cyc(1'b0, 0, 1'b0, (m_q.size() > 4) ? 4 : m_q.size(), 1'b0);
            guard++;
        end
    endtask

    initial begin
        int guard;
        int n;
        rst_n = 1'b0;
        flush = 1'b0;
        alloc_vld = 1'b0;
        alloc_num = 3'd0;
        alloc_pause_ext = 1'b0;
        retire_num = 3'd0;
        m_reset();

        rst_cycle();

        // Fill to exactly full, then one more request stalls.
        repeat (16) cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b1, 4, 1'b0, 0, 1'b0);

        // Room 3, request 4 with retire 2: stall (no bypass), then retry fires.
        cyc(1'b0, 0, 1'b0, 3, 1'b0);
        cyc(1'b1, 4, 1'b0, 2, 1'b0);
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 0, 1'b0);
        drain();

        // Walk pointers to 126 with an empty ROB, then wrap.
        guard = 0;
        while ((m_wr != 126 || m_q.size() != 0) && guard < 200) begin
            n = (126 - m_wr + PMOD) % PMOD;
            if (n > 4) n = 4;
            cyc(n > 0, n, 1'b0, (m_q.size() > 4) ? 4 : m_q.size(), 1'b0);
            guard++;
        end
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 4, 1'b0);
        cyc(1'b0, 0, 1'b0, 0, 1'b0);

        // Flush with occupancy 10, retire 1, alloc 3 requested.
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b1, 4, 1'b0, 0, 1'b0);
        cyc(1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b1, 3, 1'b0, 1, 1'b1);
        repeat (4) cyc(1'b1, 3, 1'b0, 0, 1'b0);
        drain();

        // Over-retire sets sticky error; reset clears it.
        cyc(1'b1, 1, 1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 3, 1'b0);
        repeat (2) cyc(1'b0, 0, 1'b0, 0, 1'b0);
        rst_cycle();
        cyc(1'b0, 0, 1'b0, 0, 1'b0);

        // Issue-queue pause with room available.
        repeat (2) cyc(1'b1, 2, 1'b1, 0, 1'b0);
        cyc(1'b0, 0, 1'b0, 0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 7) == 0,
                $urandom_range(0, 5), $urandom_range(0, 24) == 0);
        end
        drain();
        cyc(1'b0, 0, 1'b0, 0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
